// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-time debounce FSM,
// registered debounced level plus single-cycle press / release / long-press pulses.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_HIGH     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW_RAW = $clog2(LONG_CYCLES + 1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;

  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);
  localparam logic          LONG_EN  = (LONG_CYCLES > 0);
  localparam logic          IDLE_LVL = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic          sync1_q, sync2_q;
  logic          s;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ IDLE_LVL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Hold time restarts only on an accepted press; a release glitch keeps counting.
    if (press_d) begin
      hold_d = '0;
    end else if (LONG_EN && (state_q == PRESSED || state_q == RELEASE_WAIT) &&
                 hold_q != LONG_MAX) begin
      hold_d = hold_q + HW'(1);
    end

    long_d  = LONG_EN && (hold_q != LONG_MAX) && (hold_d == LONG_MAX);
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: active-high instance for the main scenarios,
// active-low instance for the polarity scenario.
module tb_button_debounce;

  logic clk;
  logic rst_n;
  logic btn_a, lvl_a, prs_a, rel_a, lng_a;
  logic btn_b, lvl_b, prs_b, rel_b, lng_b;

  int n_cmp = 0;
  int n_err = 0;
  int pb_cnt = 0;
  int rb_cnt = 0;

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_HIGH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a)
  );

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_HIGH(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prs_b) pb_cnt++;
    if (rel_b) rb_cnt++;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and park on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_all_a_zero(input string tag);
    chk({tag, "_level"}, lvl_a, 1'b0);
    chk({tag, "_press"}, prs_a, 1'b0);
    chk({tag, "_release"}, rel_a, 1'b0);
    chk({tag, "_long"}, lng_a, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b1;
    @(negedge clk);
    cyc(2);
    chk_all_a_zero("reset_a");
    chk("reset_b_level", lvl_b, 1'b0);
    chk("reset_b_press", prs_b, 1'b0);
    rst_n = 1'b1;
    cyc(3);
    chk_all_a_zero("idle_a");

    // Clean press, long press, release
    btn_a = 1'b1;
    cyc(6);
    chk("clean_press_early", prs_a, 1'b0);
    chk("clean_level_early", lvl_a, 1'b0);
    cyc(1);
    chk("clean_press", prs_a, 1'b1);
    chk("clean_level_on", lvl_a, 1'b1);
    chk("clean_no_long_at_press", lng_a, 1'b0);
    cyc(1);
    chk("clean_press_one_cycle", prs_a, 1'b0);
    chk("clean_level_hold", lvl_a, 1'b1);
    cyc(18);
    chk("clean_long_early", lng_a, 1'b0);
    cyc(1);
    chk("clean_long", lng_a, 1'b1);
    cyc(1);
    chk("clean_long_one_cycle", lng_a, 1'b0);
    cyc(2);
    btn_a = 1'b0;
    cyc(6);
    chk("clean_release_early", rel_a, 1'b0);
    chk("clean_level_before_rel", lvl_a, 1'b1);
    cyc(1);
    chk("clean_release", rel_a, 1'b1);
    chk("clean_level_off", lvl_a, 1'b0);
    cyc(1);
    chk("clean_release_one_cycle", rel_a, 1'b0);
    chk("clean_no_long_repeat", lng_a, 1'b0);

    // Bounce rejection: 1,0,1,0 each 2 cycles, then a final rise that holds
    cyc(5);
    for (int seg = 0; seg < 4; seg++) begin
      btn_a = (seg % 2 == 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 2; k++) begin
        cyc(1);
        chk("bounce_press", prs_a, 1'b0);
        chk("bounce_level", lvl_a, 1'b0);
      end
    end
    btn_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("bounce_press_early", prs_a, 1'b0);
      chk("bounce_level_early", lvl_a, 1'b0);
    end
    cyc(1);
    chk("bounce_press", prs_a, 1'b1);
    cyc(1);
    chk("bounce_press_single", prs_a, 1'b0);
    chk("bounce_level_on", lvl_a, 1'b1);

    // Release glitch while pressed (now press edge + 1)
    cyc(3);
    btn_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      chk("glitch_level", lvl_a, 1'b1);
      chk("glitch_release", rel_a, 1'b0);
    end
    btn_a = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cyc(1);
      chk("glitch_level_after", lvl_a, 1'b1);
      chk("glitch_release_after", rel_a, 1'b0);
      chk("glitch_long_early", lng_a, 1'b0);
    end
    cyc(1);
    chk("glitch_long", lng_a, 1'b1);
    cyc(1);
    chk("glitch_long_one_cycle", lng_a, 1'b0);
    btn_a = 1'b0;
    cyc(10);
    chk("glitch_final_level", lvl_a, 1'b0);

    // Short press of 3 cycles never accepted
    btn_a = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) btn_a = 1'b0;
      cyc(1);
      chk_all_a_zero("short");
    end

    // Reset while pressed with the button held
    btn_a = 1'b1;
    cyc(10);
    chk("rst_pre_level", lvl_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_a_zero("rst_async");
    cyc(2);
    chk_all_a_zero("rst_held");
    rst_n = 1'b1;
    cyc(6);
    chk("rst_press_early", prs_a, 1'b0);
    chk("rst_level_early", lvl_a, 1'b0);
    cyc(1);
    chk("rst_press", prs_a, 1'b1);
    chk("rst_level", lvl_a, 1'b1);
    btn_a = 1'b0;
    cyc(10);

    // Active-low polarity: 10-cycle low pulse on an idle-high pin
    chk_int("pol_idle_press_count", pb_cnt, 0);
    btn_b = 1'b0;
    cyc(6);
    chk("pol_press_early", prs_b, 1'b0);
    cyc(1);
    chk("pol_press", prs_b, 1'b1);
    chk("pol_level_on", lvl_b, 1'b1);
    cyc(3);
    btn_b = 1'b1;
    cyc(6);
    chk("pol_release_early", rel_b, 1'b0);
    chk("pol_level_hold", lvl_b, 1'b1);
    cyc(1);
    chk("pol_release", rel_b, 1'b1);
    chk("pol_level_off", lvl_b, 1'b0);
    cyc(10);
    chk_int("pol_press_count", pb_cnt, 1);
    chk_int("pol_release_count", rb_cnt, 1);
    chk("pol_no_long", lng_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
